tt_vector_player: RTL and testbench
===================================

Name: tt_vector_player

Overview:
- On-chip stimulus/response engine for the 8-bit user-project pin interface.
- Stores up to DEPTH scripted vectors, each a stimulus byte plus an expected byte.
- On start, drives each stimulus onto the DUT's ui_in bus, waits SETTLE cycles, samples the DUT's uo_out and compares it against the expected byte.
- Reports pass/fail, a saturating error count and the index of the first failing vector, so silicon self-checks without an external bench.

Parameters:
- DEPTH, 16: number of vector slots; power of two, 2..256.
- AW, 4: index width, log2(DEPTH).
- SETTLE, 2: wait cycles between applying a stimulus and sampling; 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; low freezes FSM, counters and outputs.
- clear  in  1  synchronous pulse; empties vector store, aborts any run.
- load_valid  in  1  vector write request.
- load_ready  out  1  vector write accepted when high together with load_valid.
- load_data  in  16  [15:8] stimulus, [7:0] expected.
- start  in  1  pulse; begins a run in IDLE.
- dut_ui_in  out  8  stimulus to DUT dedicated inputs (registered).
- dut_uo_out  in  8  DUT dedicated outputs (synchronous to clk).
- busy  out  1  run in progress.
- done  out  1  sticky; run finished.
- pass  out  1  done && err_count==0.
- err_count  out  8  mismatch count, saturates at 255.
- first_fail_idx  out  AW  index of first mismatch; valid when err_count!=0.
- vec_count  out  AW+1  vectors loaded, 0..DEPTH.

Behaviour:
- Reset values: all outputs 0, except load_ready=1 (IDLE, empty, ena=1, start=0). FSM=IDLE; vector storage contents undefined.
- Storage: DEPTH x 16 flops. Write at slot vec_count on load_valid && load_ready, then vec_count++.
- load_ready = ena && state==IDLE && vec_count<DEPTH && !start && !clear (combinational).
- FSM states: IDLE, APPLY, WAIT, CHECK.
- IDLE + start (ena=1, clear=0):
  - done, err_count and first_fail_idx clear to 0.
  - If vec_count==0: done=1 next cycle, busy never asserts.
  - Otherwise: idx=0, busy=1, go to APPLY.
- APPLY, one cycle: dut_ui_in <= stim[idx]; timer <= SETTLE; go to WAIT if SETTLE>0, else CHECK.
- WAIT: timer decrements each cycle; go to CHECK when timer reaches 1.
- CHECK, one cycle: dut_uo_out is sampled at the end-of-cycle edge and compared with exp[idx].
  - On mismatch: err_count increments (saturating at 255); first_fail_idx <= idx if err_count was 0.
  - If idx==vec_count-1: state IDLE, busy=0, done=1, dut_ui_in=0.
  - Otherwise: idx++ and go to APPLY.
- Timing:
  - Cost per vector = SETTLE+2 cycles.
  - busy is high for vec_count*(SETTLE+2) cycles.
  - done rises in the cycle after the last CHECK.
- done and pass hold until the next start or clear.
- Priority: rst_n > clear > start > load.
  - clear in any state: next cycle state=IDLE, vec_count=0, busy=0, done=0, err_count=0, first_fail_idx=0, dut_ui_in=0.
- start while busy: ignored.
- load_valid while busy: not accepted (load_ready=0).
- load_valid when full: not accepted; vec_count stays DEPTH.
- start and load_valid in the same IDLE cycle: start wins, load dropped.
- ena=0: all state holds, including WAIT timer and dut_ui_in; start, load and clear are ignored.
- Reset asserted mid-run: immediate return to reset values; the stored vector count is lost.
- err_count must not wrap; it stays at 255 on further mismatches.

Test Plan:
1. Reset: rst_n=0 for 3 cycles, then release -> all outputs 0, load_ready=1, vec_count=0.
2. Pass run, loopback DUT (uo_out=ui_in), SETTLE=2, vectors 0x1212, 0xA5A5, 0xFFFF, then start -> busy high 12 cycles, dut_ui_in sequence 0x12, 0xA5, 0xFF then 0x00, done=1, pass=1, err_count=0.
3. Mismatch: same loopback with vectors 0x1212, 0xA500, 0x3300 -> err_count=2, first_fail_idx=1, pass=0, done=1.
4. Full/overflow: load 16 vectors, then hold load_valid -> load_ready=0, vec_count=16, slot contents unchanged on replay.
5. Abort and priority: clear during WAIT of vector 1 -> next cycle busy=0, done=0, vec_count=0, dut_ui_in=0. start and clear in the same cycle -> busy stays 0.
6. Edges: start with vec_count=0 -> done=1, pass=1 one cycle later, busy stays 0. ena=0 for 5 cycles mid-WAIT -> total run length extends by exactly 5 cycles, result unchanged.

Source files
------------

// File: rtl/tt_vector_player.sv
// Scripted stimulus/response engine for the 8-bit user-project pin interface.
// Plays stored vectors into the DUT, compares sampled outputs and reports the verdict.
module tt_vector_player #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          clear,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [15:0]   load_data,
  input  logic          start,
  output logic [7:0]    dut_ui_in,
  input  logic [7:0]    dut_uo_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_count,
  output logic [AW-1:0] first_fail_idx,
  output logic [AW:0]   vec_count
);
  localparam int          VW       = AW + 1;
  localparam logic [AW:0] DEPTH_C  = VW'(DEPTH);
  localparam logic [7:0]  SETTLE_C = 8'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [15:0]   r_mem [DEPTH];
  logic [AW:0]   r_vec_count;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_timer;
  logic [7:0]    r_dut_ui_in;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [7:0]    r_err_count;
  logic [AW-1:0] r_first_fail_idx;

  logic          w_is_idle;
  logic          w_load_fire;
  logic          w_last;
  logic          w_mismatch;
  logic [7:0]    w_stim;
  logic [7:0]    w_exp;
  logic [7:0]    w_err_inc;

  assign w_is_idle   = (r_state == S_IDLE);
  assign load_ready  = ena && w_is_idle && (r_vec_count < DEPTH_C) && !start && !clear;
  assign w_load_fire = load_valid && load_ready;
  assign w_last      = ({1'b0, r_idx} == (r_vec_count - VW'(1)));
  assign w_stim      = r_mem[r_idx][15:8];
  assign w_exp       = r_mem[r_idx][7:0];
  assign w_mismatch  = (dut_uo_out != w_exp);
  assign w_err_inc   = (r_err_count == 8'hFF) ? 8'hFF : (r_err_count + 8'd1);

  // Vector store: written only through an accepted load, never reset.
  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      r_mem[r_vec_count[AW-1:0]] <= load_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; ena low freezes the sequence in place.
  always_comb begin
    w_next_state = r_state;
    if (!ena) begin
      w_next_state = r_state;
    end else if (clear) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (r_vec_count != {VW{1'b0}})) begin
            w_next_state = S_APPLY;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_APPLY: w_next_state = (SETTLE_C != 8'd0) ? S_WAIT : S_CHECK;
        S_WAIT:  w_next_state = (r_timer <= 8'd1) ? S_CHECK : S_WAIT;
        S_CHECK: w_next_state = w_last ? S_IDLE : S_APPLY;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Datapath: vector count, settle timer, stimulus drive and verdict registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_count      <= {VW{1'b0}};
      r_idx            <= {AW{1'b0}};
      r_timer          <= 8'd0;
      r_dut_ui_in      <= 8'd0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= 8'd0;
      r_first_fail_idx <= {AW{1'b0}};
    end else if (ena) begin
      if (clear) begin
        r_vec_count      <= {VW{1'b0}};
        r_idx            <= {AW{1'b0}};
        r_timer          <= 8'd0;
        r_dut_ui_in      <= 8'd0;
        r_busy           <= 1'b0;
        r_done           <= 1'b0;
        r_pass           <= 1'b0;
        r_err_count      <= 8'd0;
        r_first_fail_idx <= {AW{1'b0}};
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_err_count      <= 8'd0;
              r_first_fail_idx <= {AW{1'b0}};
              r_idx            <= {AW{1'b0}};
              if (r_vec_count == {VW{1'b0}}) begin
                r_done <= 1'b1;
                r_pass <= 1'b1;
              end else begin
                r_done <= 1'b0;
                r_pass <= 1'b0;
                r_busy <= 1'b1;
              end
            end else if (w_load_fire) begin
              r_vec_count <= r_vec_count + VW'(1);
            end
          end
          S_APPLY: begin
            r_dut_ui_in <= w_stim;
            r_timer     <= SETTLE_C;
          end
          S_WAIT: begin
            r_timer <= r_timer - 8'd1;
          end
          S_CHECK: begin
            if (w_mismatch) begin
              r_err_count <= w_err_inc;
              if (r_err_count == 8'd0) begin
                r_first_fail_idx <= r_idx;
              end
            end
            // Pass is judged with this final comparison folded in.
            if (w_last) begin
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_pass      <= !w_mismatch && (r_err_count == 8'd0);
              r_dut_ui_in <= 8'd0;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
          default: begin
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dut_ui_in      = r_dut_ui_in;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign first_fail_idx = r_first_fail_idx;
  assign vec_count      = r_vec_count;

endmodule

// File: tb/tb_tt_vector_player.sv
// Scoreboard bench for tt_vector_player with a loopback DUT (uo_out = ui_in).
// Expected verdicts come from a vector-list model; a monitor checks stimulus and results.
module tb_tt_vector_player;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int SETTLE = 2;
  localparam int VC     = SETTLE + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          clear = 1'b0;
  logic          load_valid = 1'b0;
  logic [15:0]   load_data = 16'h0;
  logic          start = 1'b0;
  logic          load_ready, busy, done, pass;
  logic [7:0]    dut_ui_in, dut_uo_out, err_count;
  logic [AW-1:0] first_fail_idx;
  logic [AW:0]   vec_count;

  always #5 clk = ~clk;
  assign dut_uo_out = dut_ui_in;

  tt_vector_player #(.DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .start(start), .dut_ui_in(dut_ui_in), .dut_uo_out(dut_uo_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .vec_count(vec_count)
  );

  typedef struct {
    int err;
    int ffi;
    bit pass;
    int blen;
  } res_t;

  res_t        res_q[$];
  logic [7:0]  stim_q[$];
  logic [15:0] model_mem[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: checks the stimulus at each check slot and the verdict when done rises.
  initial begin
    int act_cyc;
    int busy_cyc;
    logic prev_done;
    res_t r;
    act_cyc = 0;
    busy_cyc = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act_cyc = 0;
        busy_cyc = 0;
        prev_done = 1'b0;
      end else begin
        if (busy) begin
          busy_cyc++;
          if (ena) begin
            act_cyc++;
            if (act_cyc % VC == 0) begin
              if (stim_q.size() == 0) check("stim_unexpected", 1, 0);
              else check("dut_ui_in", dut_ui_in, stim_q.pop_front());
            end
          end
        end
        if (done && !prev_done) begin
          if (res_q.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            r = res_q.pop_front();
            check("err_count", err_count, r.err);
            if (r.err != 0) check("first_fail_idx", first_fail_idx, r.ffi);
            check("pass", pass, r.pass);
            check("busy_len", busy_cyc, r.blen);
            check("ui_in_idle", dut_ui_in, 0);
            check("busy_end", busy, 0);
          end
          act_cyc = 0;
          busy_cyc = 0;
        end else if (!busy) begin
          act_cyc = 0;
          busy_cyc = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_mem.delete();
    stim_q.delete();
  endtask

  task automatic load(input logic [15:0] d);
    bit exp_rdy;
    exp_rdy = (model_mem.size() < DEPTH);
    load_valid = 1'b1;
    load_data = d;
    @(negedge clk);
    check("load_ready", load_ready, exp_rdy);
    tick();
    load_valid = 1'b0;
    if (exp_rdy) model_mem.push_back(d);
    check("vec_count", vec_count, model_mem.size());
  endtask

  task automatic run(input int freeze, input bit poke);
    res_t r;
    int n;
    bit got;
    n = model_mem.size();
    r.err = 0;
    r.ffi = 0;
    for (int i = 0; i < n; i++) begin
      stim_q.push_back(model_mem[i][15:8]);
      if (model_mem[i][15:8] != model_mem[i][7:0]) begin
        if (r.err == 0) r.ffi = i;
        if (r.err < 255) r.err++;
      end
    end
    r.pass = (r.err == 0);
    r.blen = n * VC + ((n > 0) ? freeze : 0);
    res_q.push_back(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n > 0 && freeze > 0) begin
      tick();
      ena = 1'b0;
      repeat (freeze) tick();
      ena = 1'b1;
    end
    if (n > 0 && poke) begin
      tick();
      load_valid = 1'b1;
      load_data = 16'h5A5A;
      @(negedge clk);
      check("load_ready_busy", load_ready, 0);
      tick();
      load_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("vec_count_busy", vec_count, n);
    end
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] s;
    logic [7:0] e;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_load_ready", load_ready, 1);
    check("rst_vec_count", vec_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ffi", first_fail_idx, 0);
    check("rst_ui_in", dut_ui_in, 0);
    tick();

    // Passing run with a mid-run load attempt and stray start
    load(16'h1212); load(16'hA5A5); load(16'hFFFF);
    run(0, 1'b1);

    // Mismatching run
    do_clear();
    load(16'h1212); load(16'hA500); load(16'h3300);
    run(0, 1'b0);

    // Fill, overflow, replay
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      s = 8'($urandom);
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : s;
      load({s, e});
    end
    for (int i = 0; i < 3; i++) load(16'hDEAD);
    check("full_vec_count", vec_count, DEPTH);
    run(0, 1'b0);

    // Abort during WAIT of vector 1
    do_clear();
    load(16'h1212); load(16'hA5A5); load(16'hFFFF);
    for (int i = 0; i < 3; i++) stim_q.push_back(model_mem[i][15:8]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("pre_abort_busy", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_vec_count", vec_count, 0);
    check("abort_ui_in", dut_ui_in, 0);
    model_mem.delete();
    stim_q.delete();

    // start and clear together
    load(16'h7777);
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    model_mem.delete();
    check("sc_busy", busy, 0);
    check("sc_vec_count", vec_count, 0);
    tick();
    check("sc_busy_later", busy, 0);

    // Empty start
    do_clear();
    run(0, 1'b0);
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);

    // Freeze mid-WAIT for 5 cycles
    do_clear();
    load(16'h1212); load(16'hA5A5); load(16'hFFFF);
    run(5, 1'b0);

    // Randomised runs
    for (int k = 0; k < 6; k++) begin
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        s = 8'($urandom);
        e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : s;
        load({s, e});
      end
      run((k % 3 == 2) ? int'($urandom_range(1, 6)) : 0, 1'b0);
    end

    check("queue_drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
